// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, grant values and the arbitration rule.
// Grant encodings match addr_sel, so a grant value can drive the address mux directly.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic GNT_IF = 1'b1;
  localparam logic GNT_D  = 1'b0;

  // Round-robin choice: a lone requester wins; on contention the one not served last wins.
  function automatic logic pick_grant(input logic if_req, input logic d_req, input logic last_grant);
    if (if_req && d_req) begin
      return ~last_grant;
    end
    return if_req ? GNT_IF : GNT_D;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side handshakes and memory-side strobes around the arbiter.
// slave = arbiter view; master = fetch/LSU plus memory view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        if_ack;
  logic        d_ack;
  logic [31:0] rdata;
  logic        addr_sel;
  logic [31:0] mem_addr;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, d_ack, rdata, addr_sel, mem_addr, mem_en, mem_we, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, d_ack, rdata, addr_sel, mem_addr, mem_en, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_mux2to1.sv
// Generic two-input mux: sel = 1 picks din1, sel = 0 picks din2.
// Purely combinational.
module mux2to1 #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] din1,
  input  logic [W-1:0] din2,
  output logic [W-1:0] muxout
);
  assign muxout = sel ? din1 : din2;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one fixed-latency memory port between fetch and data requesters.
// ack lands MEM_LAT+2 cycles after grant; a losing requester simply waits with req held.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);
  import mem_port_arbiter_pkg::*;

  localparam int            CW       = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT);

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          addr_sel_q, addr_sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          start;
  logic          start_gnt;
  logic [31:0]   mem_addr;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_sel_d   = addr_sel_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    start        = 1'b0;
    start_gnt    = pick_grant(bus.if_req, bus.d_req, last_grant_q);

    case (state_q)
      ST_IDLE: begin
        addr_sel_d = GNT_IF;
        start      = bus.if_req | bus.d_req;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          rdata_d  = bus.mem_rdata;
          state_d  = ST_RESP;
          if_ack_d = (addr_sel_q == GNT_IF);
          d_ack_d  = (addr_sel_q == GNT_D);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        // The acked requester still shows req this cycle; only the other one may chain in.
        state_d    = ST_IDLE;
        addr_sel_d = GNT_IF;
        start_gnt  = ~last_grant_q;
        start      = (last_grant_q == GNT_IF) ? bus.d_req : bus.if_req;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d      = ST_ACCESS;
      addr_sel_d   = start_gnt;
      last_grant_d = start_gnt;
      cnt_d        = CNT_LOAD;
      mem_en_d     = 1'b1;
      mem_we_d     = (start_gnt == GNT_D) && bus.d_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_IF;
      addr_sel_q   <= GNT_IF;
      cnt_q        <= '0;
      rdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_sel_q   <= addr_sel_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
    end
  end

  mux2to1 #(.W(32)) u_addr_mux (
    .sel    (addr_sel_q),
    .din1   (bus.if_addr),
    .din2   (bus.d_addr),
    .muxout (mem_addr)
  );

  assign bus.mem_addr  = mem_addr;
  assign bus.addr_sel  = addr_sel_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = bus.d_wdata;
  assign bus.rdata     = rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Main instance uses MEM_LAT = 2; small MEM_LAT = 1 and 5 instances cover the latency extremes.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int L2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus2 ();
  mem_port_arbiter_if bus1 ();
  mem_port_arbiter_if bus5 ();

  mem_port_arbiter #(.MEM_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  mem_port_arbiter #(.MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  mem_port_arbiter #(.MEM_LAT(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

  int checks = 0;
  int errors = 0;

  logic [31:0] refmem [256];
  logic [31:0] devmem [256];
  logic [31:0] pipe   [L2];
  bit          dev_ready = 1'b0;

  function automatic logic [31:0] mem_init(int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0107);
  endfunction

  // Memory device: read data is only valid exactly MEM_LAT cycles after mem_en, noise otherwise.
  always @(posedge clk) begin
    if (!dev_ready) begin
      for (int i = 0; i < 256; i++) devmem[i] <= mem_init(i);
      devmem[16] <= 32'hDEAD_BEEF;
      dev_ready  <= 1'b1;
    end else if (bus2.mem_en && bus2.mem_we) begin
      devmem[bus2.mem_addr[9:2]] <= bus2.mem_wdata;
    end
    for (int i = L2 - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= (bus2.mem_en && !bus2.mem_we) ? devmem[bus2.mem_addr[9:2]] : $urandom;
  end
  assign bus2.mem_rdata = pipe[L2-1];

  task automatic zero_inputs();
    bus2.if_req = 0; bus2.d_req = 0; bus2.if_addr = 0; bus2.d_addr = 0; bus2.d_we = 0; bus2.d_wdata = 0;
    bus1.if_req = 0; bus1.d_req = 0; bus1.if_addr = 0; bus1.d_addr = 0; bus1.d_we = 0; bus1.d_wdata = 0;
    bus5.if_req = 0; bus5.d_req = 0; bus5.if_addr = 0; bus5.d_addr = 0; bus5.d_we = 0; bus5.d_wdata = 0;
    bus1.mem_rdata = 0; bus5.mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    zero_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    zero_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus2.addr_sel !== 1'b1) begin errors++; $display("FAIL reset_addr_sel got %b want 1", bus2.addr_sel); end
    checks++; if (bus2.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b want 0", bus2.mem_en); end
    checks++; if (bus2.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", bus2.mem_we); end
    checks++; if (bus2.if_ack !== 1'b0 || bus2.d_ack !== 1'b0) begin errors++; $display("FAIL reset_acks got %b%b want 00", bus2.if_ack, bus2.d_ack); end
    checks++; if (bus2.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus2.rdata); end
    checks++; if (bus5.rdata !== 32'h0 || bus1.addr_sel !== 1'b1) begin errors++; $display("FAIL reset_small_builds got %h/%b want 0/1", bus5.rdata, bus1.addr_sel); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      bus2.if_req  = (c <= 4);
      bus2.if_addr = 32'h0000_0040;
      @(negedge clk);
      checks++; if (bus2.mem_en !== (c == 1)) begin errors++; $display("FAIL fetch_mem_en c=%0d got %b want %b", c, bus2.mem_en, c == 1); end
      checks++; if (bus2.if_ack !== (c == 4)) begin errors++; $display("FAIL fetch_if_ack c=%0d got %b want %b", c, bus2.if_ack, c == 4); end
      checks++; if (bus2.d_ack !== 1'b0) begin errors++; $display("FAIL fetch_d_ack c=%0d got %b want 0", c, bus2.d_ack); end
      if (c == 1) begin
        checks++; if (bus2.mem_addr !== 32'h40 || bus2.mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem_addr_we got %h/%b want 00000040/0", bus2.mem_addr, bus2.mem_we); end
      end
      if (c == 4) begin
        checks++; if (bus2.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fetch_rdata got %h want deadbeef", bus2.rdata); end
      end
    end
  endtask

  task automatic test_single_store();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      bus2.d_req   = (c <= 4);
      bus2.d_we    = 1'b1;
      bus2.d_addr  = 32'h0000_0100;
      bus2.d_wdata = 32'h1234_5678;
      @(negedge clk);
      checks++; if (bus2.addr_sel !== !(c >= 1 && c <= 4)) begin errors++; $display("FAIL store_addr_sel c=%0d got %b want %b", c, bus2.addr_sel, !(c >= 1 && c <= 4)); end
      checks++; if (bus2.mem_en !== (c == 1) || bus2.mem_we !== (c == 1)) begin errors++; $display("FAIL store_strobes c=%0d got %b%b want %b%b", c, bus2.mem_en, bus2.mem_we, c == 1, c == 1); end
      checks++; if (bus2.d_ack !== (c == 4) || bus2.if_ack !== 1'b0) begin errors++; $display("FAIL store_acks c=%0d got d%b i%b want d%b i0", c, bus2.d_ack, bus2.if_ack, c == 4); end
      if (c == 1) begin
        checks++; if (bus2.mem_addr !== 32'h100 || bus2.mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL store_addr_data got %h/%h want 00000100/12345678", bus2.mem_addr, bus2.mem_wdata); end
      end
    end
    bus2.d_we = 1'b0;
    refmem[64] = 32'h1234_5678;
  endtask

  task automatic test_contention();
    do_reset();
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      bus2.if_req = 1'b1; bus2.if_addr = 32'h80;
      bus2.d_req  = 1'b1; bus2.d_addr  = 32'h84; bus2.d_we = 1'b0;
      @(negedge clk);
      checks++; if (bus2.d_ack !== (c % 8 == 4)) begin errors++; $display("FAIL contend_d_ack c=%0d got %b want %b", c, bus2.d_ack, c % 8 == 4); end
      checks++; if (bus2.if_ack !== (c % 8 == 0 && c > 0)) begin errors++; $display("FAIL contend_if_ack c=%0d got %b want %b", c, bus2.if_ack, c % 8 == 0 && c > 0); end
      if (c % 8 == 4) begin
        checks++; if (bus2.rdata !== refmem[33]) begin errors++; $display("FAIL contend_d_rdata c=%0d got %h want %h", c, bus2.rdata, refmem[33]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      rst          = (c == 2);
      bus2.if_req  = (c <= 1) || (c >= 3 && c <= 7);
      bus2.if_addr = (c < 3) ? 32'h40 : 32'h44;
      @(negedge clk);
      checks++; if (bus2.if_ack !== (c == 7)) begin errors++; $display("FAIL rstmid_if_ack c=%0d got %b want %b", c, bus2.if_ack, c == 7); end
      checks++; if (bus2.mem_en !== (c == 1 || c == 4)) begin errors++; $display("FAIL rstmid_mem_en c=%0d got %b want %b", c, bus2.mem_en, c == 1 || c == 4); end
      if (c == 3) begin
        checks++; if (bus2.addr_sel !== 1'b1 || bus2.rdata !== 32'h0) begin errors++; $display("FAIL rstmid_cleared got %b/%h want 1/0", bus2.addr_sel, bus2.rdata); end
      end
      if (c == 4) begin
        checks++; if (bus2.mem_addr !== 32'h44) begin errors++; $display("FAIL rstmid_mem_addr got %h want 00000044", bus2.mem_addr); end
      end
      if (c == 7) begin
        checks++; if (bus2.rdata !== refmem[17]) begin errors++; $display("FAIL rstmid_rdata got %h want %h", bus2.rdata, refmem[17]); end
      end
    end
  endtask

  task automatic test_hold_past_ack();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      bus2.if_req  = (c <= 9);
      bus2.if_addr = 32'h48;
      @(negedge clk);
      checks++; if (bus2.mem_en !== (c == 1 || c == 6)) begin errors++; $display("FAIL hold_mem_en c=%0d got %b want %b", c, bus2.mem_en, c == 1 || c == 6); end
      checks++; if (bus2.if_ack !== (c == 4 || c == 9)) begin errors++; $display("FAIL hold_if_ack c=%0d got %b want %b", c, bus2.if_ack, c == 4 || c == 9); end
      if (c == 9) begin
        checks++; if (bus2.rdata !== refmem[18]) begin errors++; $display("FAIL hold_rdata got %h want %h", bus2.rdata, refmem[18]); end
      end
    end
  endtask

  task automatic test_latency();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      bus1.if_req = (c <= 3); bus1.if_addr = 32'h10;
      bus5.if_req = (c <= 7); bus5.if_addr = 32'h50;
      bus1.mem_rdata = (c == 2) ? 32'h1111_0001 : $urandom;
      bus5.mem_rdata = (c == 6) ? 32'h5555_0005 : $urandom;
      @(negedge clk);
      checks++; if (bus1.mem_en !== (c == 1) || bus5.mem_en !== (c == 1)) begin errors++; $display("FAIL lat_mem_en c=%0d got %b/%b want %b", c, bus1.mem_en, bus5.mem_en, c == 1); end
      checks++; if (bus1.if_ack !== (c == 3)) begin errors++; $display("FAIL lat1_if_ack c=%0d got %b want %b", c, bus1.if_ack, c == 3); end
      checks++; if (bus5.if_ack !== (c == 7)) begin errors++; $display("FAIL lat5_if_ack c=%0d got %b want %b", c, bus5.if_ack, c == 7); end
      if (c == 3) begin
        checks++; if (bus1.rdata !== 32'h1111_0001) begin errors++; $display("FAIL lat1_rdata got %h want 11110001", bus1.rdata); end
      end
      if (c == 7) begin
        checks++; if (bus5.rdata !== 32'h5555_0005) begin errors++; $display("FAIL lat5_rdata got %h want 55550005", bus5.rdata); end
      end
    end
  endtask

  // Transaction-level model: a grant at cycle g yields mem_en at g+1 and the ack at g+MEM_LAT+2.
  task automatic test_random();
    bit          busy = 0, if_pend = 0, d_pend = 0, do_g;
    logic        who = GNT_IF, last = GNT_IF, gx;
    int          g = 0;
    logic [31:0] cur_addr = 0, cur_wdata = 0, exp_rd = 0;
    logic        cur_we = 0;
    logic        e_en, e_ia, e_da, e_sel;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!if_pend && $urandom_range(0, 3) == 0) begin
        if_pend = 1; bus2.if_addr = {22'd0, 8'($urandom_range(0, 31)), 2'b00};
      end
      if (!d_pend && $urandom_range(0, 3) == 0) begin
        d_pend = 1; bus2.d_addr = {22'd0, 8'($urandom_range(0, 31)), 2'b00};
        bus2.d_we = 1'($urandom_range(0, 1)); bus2.d_wdata = $urandom;
      end
      bus2.if_req = if_pend;
      bus2.d_req  = d_pend;
      @(negedge clk);
      e_en  = busy && (c == g + 1);
      e_ia  = busy && (c == g + L2 + 2) && (who == GNT_IF);
      e_da  = busy && (c == g + L2 + 2) && (who == GNT_D);
      e_sel = (busy && c > g) ? who : GNT_IF;
      checks++; if (bus2.mem_en !== e_en) begin errors++; $display("FAIL rnd_mem_en c=%0d got %b want %b", c, bus2.mem_en, e_en); end
      checks++; if (bus2.if_ack !== e_ia || bus2.d_ack !== e_da) begin errors++; $display("FAIL rnd_acks c=%0d got i%b d%b want i%b d%b", c, bus2.if_ack, bus2.d_ack, e_ia, e_da); end
      checks++; if (bus2.addr_sel !== e_sel) begin errors++; $display("FAIL rnd_addr_sel c=%0d got %b want %b", c, bus2.addr_sel, e_sel); end
      if (e_en) begin
        checks++; if (bus2.mem_addr !== cur_addr || bus2.mem_we !== cur_we || (cur_we && bus2.mem_wdata !== cur_wdata)) begin
          errors++; $display("FAIL rnd_access c=%0d got %h/%b/%h want %h/%b/%h", c, bus2.mem_addr, bus2.mem_we, bus2.mem_wdata, cur_addr, cur_we, cur_wdata);
        end
      end
      if (e_ia || (e_da && !cur_we)) begin
        checks++; if (bus2.rdata !== exp_rd) begin errors++; $display("FAIL rnd_rdata c=%0d got %h want %h", c, bus2.rdata, exp_rd); end
      end
      do_g = 0;
      gx   = GNT_IF;
      if (busy && c == g + L2 + 2) begin
        if (who == GNT_IF) if_pend = 0; else d_pend = 0;
        busy = 0;
        if (who == GNT_IF ? bus2.d_req : bus2.if_req) begin do_g = 1; gx = ~who; end
      end else if (!busy && (bus2.if_req || bus2.d_req)) begin
        do_g = 1;
        gx   = (bus2.if_req && bus2.d_req) ? ~last : (bus2.if_req ? GNT_IF : GNT_D);
      end
      if (do_g) begin
        busy = 1; who = gx; g = c; last = gx;
        if (gx == GNT_IF) begin cur_addr = bus2.if_addr; cur_we = 0; cur_wdata = 0; end
        else begin cur_addr = bus2.d_addr; cur_we = bus2.d_we; cur_wdata = bus2.d_wdata; end
        if (cur_we) refmem[cur_addr[9:2]] = cur_wdata;
        else exp_rd = refmem[cur_addr[9:2]];
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) refmem[i] = mem_init(i);
    refmem[16] = 32'hDEAD_BEEF;
    test_reset();
    test_single_fetch();
    test_single_store();
    test_contention();
    test_reset_mid();
    test_hold_past_ack();
    test_latency();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single 32-bit memory port between instruction fetch (IF) and data load/store (D) requesters. It arbitrates round-robin on contention and sequences each access through a fixed-latency memory. It drives the address-mux select so the granted requester's address reaches the memory. The block sits between the fetch/LSU logic and the memory model in the CPU datapath.

## Interface
- MEM_LAT, 2: cycles from mem_en to valid mem_rdata; legal range ≥1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_ack.
- if_addr  in  32  fetch address.
- d_req  in  1  data request; held high with d_addr/d_we/d_wdata stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- if_ack  out  1  one-cycle pulse: fetch complete, rdata valid.
- d_ack  out  1  one-cycle pulse: data access complete, rdata valid for loads.
- rdata  out  32  registered read data, valid in the ack cycle.
- addr_sel  out  1  address-mux select: 1 = fetch address, 0 = data address.
- mem_addr  out  32  memory address (output of the address mux).
- mem_en  out  1  one-cycle access strobe.
- mem_we  out  1  write strobe, coincident with mem_en.
- mem_wdata  out  32  equals d_wdata.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE, addr_sel = 1.
  - One request: grant that requester.
  - Both requesting: grant the requester not in last_grant.
  - On grant: set addr_sel, update last_grant, load counter = MEM_LAT, go to ACCESS.
- ACCESS:
  - mem_en = 1 in the first ACCESS cycle only.
  - mem_we = d_we in that cycle when D is granted; otherwise 0.
  - Counter decrements each cycle. At 0, capture mem_rdata into rdata and go to RESP.
- RESP: assert the granted requester's ack for exactly one cycle, then go to IDLE.
- addr_sel is held constant from the grant cycle through RESP. A request arriving mid-transaction waits.
- Stores also occupy MEM_LAT cycles. rdata for a store is don't-care.
- Counter width is $clog2(MEM_LAT+1).
- Reset values:
  - state = IDLE, last_grant = IF (the first contested grant goes to D).
  - addr_sel = 1; mem_en, mem_we, if_ack, d_ack = 0; rdata = 0; counter = 0.
- Reset mid-transaction aborts the access. No ack is issued, and no further mem_en occurs until a new grant.

## Timing
- Request sampled high in IDLE at cycle 0.
- mem_en high at cycle 1, with mem_addr already selected.
- mem_rdata is captured at the end of cycle 1+MEM_LAT.
- ack and rdata are valid at cycle 2+MEM_LAT. With MEM_LAT = 2, ack is at cycle 4.
- Throughput: one access per MEM_LAT+2 cycles.
- The requester drops req no later than the cycle after ack. If req is still high in that cycle (IDLE), the arbiter treats it as a new request.
- Both req rising in the same cycle: exactly one grant. The other requester is served immediately after the RESP cycle.
- Back-to-back contention alternates IF, D, IF, … with no starvation.

## Structure
- Shared include arb_defs.vh holds:
  - state encodings (IDLE/ACCESS/RESP)
  - grant encodings (GNT_IF = 1, GNT_D = 0, matching addr_sel)
- One sub-module: the existing 32-bit mux2to1 instance.
  - sel = addr_sel, din1 = if_addr, din2 = d_addr, muxout = mem_addr.
- The FSM, counter and rdata register are inline.

## Test plan
- Single fetch, MEM_LAT = 2: if_req at cycle 0 with if_addr = 0x0000_0040; mem returns 0xDEAD_BEEF.
  - Expect mem_en at cycle 1 with mem_addr = 0x40 and mem_we = 0.
  - Expect if_ack at cycle 4 with rdata = 0xDEAD_BEEF; d_ack stays 0.
- Single store: d_req, d_we = 1, d_addr = 0x100, d_wdata = 0x1234_5678.
  - Expect addr_sel = 0 and mem_en = mem_we = 1 for one cycle, with mem_addr = 0x100 and mem_wdata = 0x1234_5678.
  - Expect d_ack at cycle 4.
- Simultaneous if_req and d_req from reset:
  - Expect D granted first (d_ack at cycle 4), IF second (if_ack at cycle 8).
  - Both held continuously: acks alternate IF/D thereafter.
- Reset asserted in the second ACCESS cycle: no ack appears. The FSM is in IDLE the cycle after reset deasserts; a new request then completes normally.
- MEM_LAT = 1 and MEM_LAT = 5 builds: ack at cycles 3 and 7 respectively.
- req held high one cycle past ack: a second access starts (mem_en at ack+2), confirming the new-request rule.
